// File: rtl/io_value_arbiter_if.sv
// io_value_arbiter_if: the producer, storage and CPU-read signals that surround
// the value-storage arbiter. The slave modport is the arbiter's view; the master
// modport is the view of everything around it (producers, storage, CPU).
interface io_value_arbiter_if;
   logic       cpu_wr_req;
   logic [7:0] cpu_wr_data;
   logic       cpu_wr_ack;
   logic       uart_rx_valid;
   logic [7:0] uart_rx_data;
   logic       uart_rx_ack;
   logic       vs_input_trigger;
   logic [7:0] vs_input_value;
   logic       vs_output_trigger;
   logic [7:0] vs_output_value;
   logic       vs_output_ready;
   logic       cpu_rd_valid;
   logic [7:0] cpu_rd_data;
   logic       cpu_rd_ack;
   logic       overrun;
   logic       timeout;

   modport slave (
      input  cpu_wr_req, cpu_wr_data, uart_rx_valid, uart_rx_data,
             vs_output_trigger, vs_output_value, cpu_rd_ack,
      output cpu_wr_ack, uart_rx_ack, vs_input_trigger, vs_input_value,
             vs_output_ready, cpu_rd_valid, cpu_rd_data, overrun, timeout
   );

   modport master (
      output cpu_wr_req, cpu_wr_data, uart_rx_valid, uart_rx_data,
             vs_output_trigger, vs_output_value, cpu_rd_ack,
      input  cpu_wr_ack, uart_rx_ack, vs_input_trigger, vs_input_value,
             vs_output_ready, cpu_rd_valid, cpu_rd_data, overrun, timeout
   );
endinterface

// File: rtl/io_value_arbiter.sv
// io_value_arbiter: round-robin sharing of the value storage's write strobe
// between the CPU and the UART, plus a one-byte holding register on the
// storage's output that returns the ready strobe once the CPU has read it.
// Optional macro IO_ARB_TIMEOUT_EN adds an auto-release of an unread held byte
// after TIMEOUT_CYCLES cycles. All outputs are registered.
module io_value_arbiter #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input logic               clk,
   input logic               rst,
   io_value_arbiter_if.slave bus
);
   typedef enum logic {W_IDLE = 1'b0, W_GUARD = 1'b1} w_state_t;
   typedef enum logic [1:0] {R_IDLE = 2'd0, R_HOLD = 2'd1, R_RELEASE = 2'd2} r_state_t;

   w_state_t   w_state_q, w_state_d;
   logic       prio_uart_q, prio_uart_d;   // 1: UART wins the next tie
   logic       wr_trig_q, wr_trig_d;
   logic [7:0] wr_val_q, wr_val_d;
   logic       cpu_ack_q, cpu_ack_d;
   logic       uart_ack_q, uart_ack_d;
   logic       grant_cpu_s, grant_uart_s;

   r_state_t   r_state_q, r_state_d;
   logic       rd_valid_q, rd_valid_d;
   logic [7:0] rd_data_q, rd_data_d;
   logic       ready_q, ready_d;
   logic       overrun_q, overrun_d;
   logic       tmo_hit_s;

`ifdef IO_ARB_TIMEOUT_EN
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0] hold_cnt_q, hold_cnt_d;
   logic        timeout_q, timeout_d;

   // Auto-release fires only when the CPU is not acking in the same cycle.
   assign tmo_hit_s = (hold_cnt_q == TMO_LAST) && !bus.cpu_rd_ack;
`else
   assign tmo_hit_s = 1'b0;
   // The timeout length only matters when the auto-release is built.
   if (TIMEOUT_CYCLES < 2) begin : g_timeout_param_unused
   end
`endif

   // A tie goes to whichever requester was not granted last time.
   assign grant_cpu_s  = bus.cpu_wr_req    && (!bus.uart_rx_valid || !prio_uart_q);
   assign grant_uart_s = bus.uart_rx_valid && (!bus.cpu_wr_req    ||  prio_uart_q);

   // Write arbiter next state: grant in W_IDLE, then one guard cycle.
   always_comb begin
      w_state_d   = w_state_q;
      prio_uart_d = prio_uart_q;
      wr_trig_d   = 1'b0;
      wr_val_d    = wr_val_q;
      cpu_ack_d   = 1'b0;
      uart_ack_d  = 1'b0;
      case (w_state_q)
         W_IDLE: begin
            if (grant_cpu_s) begin
               wr_trig_d   = 1'b1;
               wr_val_d    = bus.cpu_wr_data;
               cpu_ack_d   = 1'b1;
               prio_uart_d = 1'b1;
               w_state_d   = W_GUARD;
            end else if (grant_uart_s) begin
               wr_trig_d   = 1'b1;
               wr_val_d    = bus.uart_rx_data;
               uart_ack_d  = 1'b1;
               prio_uart_d = 1'b0;
               w_state_d   = W_GUARD;
            end else begin
               w_state_d   = W_IDLE;
            end
         end
         W_GUARD: w_state_d = W_IDLE;
         default: w_state_d = W_IDLE;
      endcase
   end

   // Read path next state: capture, hold until ack (or timeout), release.
   always_comb begin
      r_state_d  = r_state_q;
      rd_valid_d = rd_valid_q;
      rd_data_d  = rd_data_q;
      ready_d    = 1'b0;
      overrun_d  = overrun_q;
`ifdef IO_ARB_TIMEOUT_EN
      hold_cnt_d = hold_cnt_q;
      timeout_d  = timeout_q;
`endif
      case (r_state_q)
         R_IDLE: begin
            if (bus.vs_output_trigger) begin
               rd_data_d  = bus.vs_output_value;
               rd_valid_d = 1'b1;
               r_state_d  = R_HOLD;
`ifdef IO_ARB_TIMEOUT_EN
               hold_cnt_d = 16'd0;
`endif
            end else begin
               r_state_d  = R_IDLE;
            end
         end
         R_HOLD: begin
            if (bus.vs_output_trigger) begin
               overrun_d = 1'b1;
            end else begin
               overrun_d = overrun_q;
            end
            if (bus.cpu_rd_ack || tmo_hit_s) begin
               rd_valid_d = 1'b0;
               ready_d    = 1'b1;
               r_state_d  = R_RELEASE;
`ifdef IO_ARB_TIMEOUT_EN
               timeout_d  = timeout_q || tmo_hit_s;
`endif
            end else begin
               r_state_d  = R_HOLD;
`ifdef IO_ARB_TIMEOUT_EN
               hold_cnt_d = hold_cnt_q + 16'd1;
`endif
            end
         end
         R_RELEASE: begin
            if (bus.vs_output_trigger) begin
               overrun_d = 1'b1;
            end else begin
               overrun_d = overrun_q;
            end
            r_state_d = R_IDLE;
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   // State and output registers; every output drops to 0 on reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         w_state_q   <= W_IDLE;
         prio_uart_q <= 1'b0;
         wr_trig_q   <= 1'b0;
         wr_val_q    <= 8'h00;
         cpu_ack_q   <= 1'b0;
         uart_ack_q  <= 1'b0;
         r_state_q   <= R_IDLE;
         rd_valid_q  <= 1'b0;
         rd_data_q   <= 8'h00;
         ready_q     <= 1'b0;
         overrun_q   <= 1'b0;
`ifdef IO_ARB_TIMEOUT_EN
         hold_cnt_q  <= 16'd0;
         timeout_q   <= 1'b0;
`endif
      end else begin
         w_state_q   <= w_state_d;
         prio_uart_q <= prio_uart_d;
         wr_trig_q   <= wr_trig_d;
         wr_val_q    <= wr_val_d;
         cpu_ack_q   <= cpu_ack_d;
         uart_ack_q  <= uart_ack_d;
         r_state_q   <= r_state_d;
         rd_valid_q  <= rd_valid_d;
         rd_data_q   <= rd_data_d;
         ready_q     <= ready_d;
         overrun_q   <= overrun_d;
`ifdef IO_ARB_TIMEOUT_EN
         hold_cnt_q  <= hold_cnt_d;
         timeout_q   <= timeout_d;
`endif
      end
   end

   assign bus.vs_input_trigger = wr_trig_q;
   assign bus.vs_input_value   = wr_val_q;
   assign bus.cpu_wr_ack       = cpu_ack_q;
   assign bus.uart_rx_ack      = uart_ack_q;
   assign bus.cpu_rd_valid     = rd_valid_q;
   assign bus.cpu_rd_data      = rd_data_q;
   assign bus.vs_output_ready  = ready_q;
   assign bus.overrun          = overrun_q;
`ifdef IO_ARB_TIMEOUT_EN
   assign bus.timeout          = timeout_q;
`else
   assign bus.timeout          = 1'b0;
`endif
endmodule

// File: doc/io_value_arbiter.md
# io_value_arbiter

- Sits between the 8-bit value storage register and its two byte producers: the CPU MMIO write port and the UART receive path.
- Shares the storage's single input strobe between both producers by round-robin, and issues one write at a time.
- Captures each byte the storage emits into a holding register and presents it to the CPU. It returns the storage's ready strobe only after the CPU consumes the byte.

## Interface
Parameters:
- TIMEOUT_CYCLES, 1024, CPU read-acknowledge timeout in clk cycles; used only when IO_ARB_TIMEOUT_EN is defined; legal range 2..65535.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cpu_wr_req  in  1  CPU requests a storage write; held until acked.
- cpu_wr_data  in  8  CPU write byte; stable while cpu_wr_req is high.
- cpu_wr_ack  out  1  one-cycle pulse: CPU byte written.
- uart_rx_valid  in  1  UART byte available; held until acked.
- uart_rx_data  in  8  UART byte.
- uart_rx_ack  out  1  one-cycle pulse: UART byte written.
- vs_input_trigger  out  1  one-cycle write strobe to the storage.
- vs_input_value  out  8  write byte to the storage.
- vs_output_trigger  in  1  one-cycle strobe from the storage: byte emitted.
- vs_output_value  in  8  byte emitted by the storage.
- vs_output_ready  out  1  one-cycle pulse to the storage: emitted byte consumed.
- cpu_rd_valid  out  1  holding register full.
- cpu_rd_data  out  8  holding register contents.
- cpu_rd_ack  in  1  CPU consumes the held byte; sampled only while cpu_rd_valid is high.
- overrun  out  1  sticky: a storage strobe arrived while the holding register was full.
- timeout  out  1  sticky: held byte auto-released; constant 0 when IO_ARB_TIMEOUT_EN is undefined.

## Operation
Write arbiter, states W_IDLE and W_GUARD:
- W_IDLE: if any request is high, grant one requester.
  - Both requesting: grant the requester not granted last time.
  - Priority pointer resets to "CPU first".
- On grant, in the same registered cycle:
  - vs_input_trigger=1;
  - vs_input_value = the granted requester's data;
  - the granted requester's ack=1;
  - priority pointer flips to the other requester;
  - next state W_GUARD.
- W_GUARD: all write outputs 0; unconditionally return to W_IDLE. The guard cycle lets a requester drop its request after the ack.
- Write throughput is at most one write every 2 cycles.
- vs_input_value holds its last written byte; it is 0 after reset.

Read path, states R_IDLE, R_HOLD, R_RELEASE:
- R_IDLE: on vs_output_trigger, latch vs_output_value into cpu_rd_data, set cpu_rd_valid=1, and go to R_HOLD.
- R_HOLD, on cpu_rd_ack=1: cpu_rd_valid<=0, vs_output_ready<=1, go to R_RELEASE.
- R_RELEASE: vs_output_ready<=0, go to R_IDLE. cpu_rd_data keeps its value.
- vs_output_trigger in R_HOLD or R_RELEASE:
  - the byte is dropped and overrun<=1;
  - the holding register is unchanged;
  - the pending release still completes normally.
- overrun and timeout clear only on rst.

Simultaneous events:
- The write path and the read path are independent. A write grant and a read capture or release may occur in the same cycle.
- A storage strobe in the same cycle as vs_output_ready is treated as overrun only if the read state is not R_IDLE.

Reset:
- All outputs are 0 immediately on rst assertion.
- States go to W_IDLE and R_IDLE, and the priority pointer goes to CPU.
- A held byte is discarded and no ready strobe is sent.
- A mid-grant ack already asserted drops at once.

## Timing
- Request high at edge N (W_IDLE): vs_input_trigger and ack are high during cycle N+1, low at N+2.
- Next grant no earlier than edge N+2.
- vs_output_trigger at edge N: cpu_rd_valid high from N+1.
- cpu_rd_ack sampled at edge M: cpu_rd_valid low and vs_output_ready high during M+1; vs_output_ready low at M+2.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- IO_ARB_TIMEOUT_EN defined:
  - a 16-bit counter clears on entry to R_HOLD and increments each R_HOLD cycle without cpu_rd_ack;
  - when the count reaches TIMEOUT_CYCLES-1 without ack, act as if cpu_rd_ack=1 and set timeout<=1;
  - a real ack in the same cycle takes precedence and does not set timeout.
- IO_ARB_TIMEOUT_EN undefined: no counter is built; R_HOLD waits indefinitely; timeout is tied to 0.

## Test plan
- Single write: CPU req with 0xA5 → one vs_input_trigger pulse with value 0xA5 and one cpu_wr_ack pulse; uart_rx_ack stays 0.
- Contention: CPU 0x11 and UART 0x22 both held from reset → writes 0x11, then 0x22, then 0x11, spaced 2 cycles apart, with acks matching.
- Read handshake: vs_output_trigger with 0x3C → cpu_rd_valid=1 and cpu_rd_data=0x3C. cpu_rd_ack 5 cycles later → one vs_output_ready pulse one cycle after the ack.
- Overrun: second vs_output_trigger with 0x77 while holding 0x3C → data stays 0x3C and overrun=1 until rst.
- Timeout (IO_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8): no ack → vs_output_ready pulse 8 cycles after cpu_rd_valid rises, and timeout=1.
- Reset mid-hold: rst during R_HOLD → cpu_rd_valid=0, no vs_output_ready pulse; the next vs_output_trigger is captured normally.
